rotate_arbiter: RTL

//  Shares one N-bit rotate-left barrel datapath between REQS requesters.

---
 rtl/rotate_pkg.sv | 14 +
 rtl/rotl_core.sv | 21 ++
 rtl/rotate_arbiter.sv | 82 ++++++++
 3 files changed

// File: rtl/rotate_pkg.sv
// Shared types and helpers for the rotate arbiter slice.
package rotate_pkg;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_t;

  // Width helper that never returns zero, so a 1-entry dimension still gets a bit.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rotl_core.sv
// Combinational rotate-left: log2(N) stages, stage s rotates by 2**s when shift[s] is set.
module rotl_core
  import rotate_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = clog2_min1(N)
) (
  input  logic [SW-1:0] shift,
  input  logic [N-1:0]  in,
  output logic [N-1:0]  out
);

  always_comb begin
    // NOTE: blocking assignments in always_comb so each stage sees the previous stage's value.
    out = in;
    for (int s = 0; s < SW; s++) begin
      if (shift[s]) out = (out << (1 << s)) | (out >> (N - (1 << s)));
    end
  end

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one rotate-left datapath between REQS requesters,
// with a single registered response tagged by requester id.
module rotate_arbiter
  import rotate_pkg::*;
#(
  parameter int N    = 8,
  parameter int REQS = 4,
  localparam int SW  = clog2_min1(N),
  localparam int IW  = clog2_min1(REQS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQS-1:0]    req_valid,
  output logic [REQS-1:0]    req_ready,
  input  logic [REQS*N-1:0]  req_data,
  input  logic [REQS*SW-1:0] req_shift,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N-1:0]       rsp_data,
  output logic [IW-1:0]      rsp_id
);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant_id;
  logic          any_valid;
  logic          can_accept;
  logic          fire;
  logic [N-1:0]  sel_data;
  logic [SW-1:0] sel_shift;
  logic [N-1:0]  rot_data;

  // Holding can_accept low while rst_n is low keeps grants off during reset.
  assign can_accept = rst_n & ((state == ST_EMPTY) | rsp_ready);

  always_comb begin
    // NOTE: defaults first so every path assigns these and no latch is inferred.
    grant_id  = '0;
    any_valid = 1'b0;
    // Walk downward so the lowest offset from rr_ptr is the last (winning) assignment.
    for (int k = REQS - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % REQS]) begin
        grant_id  = IW'((int'(rr_ptr) + k) % REQS);
        any_valid = 1'b1;
      end
    end
  end

  assign req_ready = (can_accept && any_valid) ? ({{(REQS-1){1'b0}}, 1'b1} << grant_id) : '0;
  assign fire      = can_accept & any_valid;

  assign sel_data  = req_data[int'(grant_id)*N +: N];
  assign sel_shift = req_shift[int'(grant_id)*SW +: SW];

  rotl_core #(.N(N), .SW(SW)) u_rotl (
    .shift (sel_shift),
    .in    (sel_data),
    .out   (rot_data)
  );

  assign rsp_valid = (state == ST_FULL);

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      rsp_data <= '0;
      rsp_id   <= '0;
      rr_ptr   <= '0;
    end else begin
      if (fire) begin
        state    <= ST_FULL;
        rsp_data <= rot_data;
        rsp_id   <= grant_id;
        rr_ptr   <= (grant_id == IW'(REQS - 1)) ? '0 : grant_id + 1'b1;
      end else if (rsp_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule
